fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL provide port i_clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL provide port i_rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL provide port i_redirect, input, 1: a taken branch or jump (the control unit's pc_sel) is requesting a redirect.
REQ-005 SHALL provide port i_redirect_pc, input, 32: the redirect target address.
REQ-006 SHALL provide port o_imem_req, output, 1: an instruction-memory read request is valid.
REQ-007 SHALL provide port o_imem_addr, output, 32: the request address.
REQ-008 SHALL provide port i_imem_ready, input, 1: memory accepts the request this cycle.
REQ-009 SHALL provide port i_imem_rvalid, input, 1: a read response is valid; responses return in order, at least 1 cycle after acceptance.
REQ-010 SHALL provide port i_imem_rdata, input, 32: the response instruction word.
REQ-011 SHALL provide port o_instr, output, 32: the instruction delivered to decode/control.
REQ-012 SHALL provide port o_pc, output, 32: the address of o_instr.
REQ-013 SHALL provide port o_instr_vld, output, 1: o_instr/o_pc are valid.
REQ-014 SHALL provide port i_instr_rdy, input, 1: downstream consumes this cycle.
REQ-015 SHALL provide port o_insn_misalign, output, 1: misaligned redirect flag (present only under the configuration macro).

Function
REQ-016 SHALL hold a fetch_pc register, a resp_pc register, a 2-entry {pc,instr} FIFO, a 2-bit outstanding counter and a 2-bit drop counter.
REQ-017 SHALL drive o_imem_req from registered state only: high iff outstanding + FIFO count < 2 and not halted (REQ-031).
REQ-018 SHALL drive o_imem_addr = fetch_pc, and SHALL hold fetch_pc stable while o_imem_req=1 and i_imem_ready=0.
REQ-019 SHALL treat o_imem_req & i_imem_ready as a handshake: fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and outstanding += 1.
REQ-020 SHALL, on i_imem_rvalid with drop > 0, discard the response, decrement drop and decrement outstanding.
REQ-021 SHALL, on i_imem_rvalid with drop = 0, push {resp_pc, i_imem_rdata} into the FIFO, set resp_pc += 4 and decrement outstanding.
REQ-022 SHALL drive o_instr_vld = FIFO not empty, with o_instr/o_pc taken from the FIFO head; latency from response to o_instr_vld is exactly 1 cycle.
REQ-023 SHALL drive o_instr = 32'h0000_0013 (NOP) and o_pc = head pc when o_instr_vld=0.
REQ-024 SHALL pop the FIFO head on o_instr_vld & i_instr_rdy; a simultaneous push and pop leaves the count unchanged.
REQ-025 SHALL never overflow the FIFO, because credits cover all in-flight responses.
REQ-026 SHALL, on i_redirect=1, in the same edge: flush the FIFO, set fetch_pc and resp_pc to the target, and set drop = outstanding after this cycle's handshake/response updates.
REQ-027 SHALL count a handshake in the redirect cycle as outstanding-to-drop, and SHALL discard a response arriving in the redirect cycle.
REQ-028 SHALL drive o_instr_vld=0 in the cycle after a redirect; a pop in the redirect cycle is ignored.
REQ-029 SHALL, when i_rst is asserted mid-operation, abandon all in-flight requests; the memory side is reset by the same i_rst.

Reset
REQ-030 SHALL, while i_rst=1, asynchronously set: fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, o_imem_req=0, o_instr_vld=0, o_instr=32'h0000_0013, o_pc=RESET_PC, o_insn_misalign=0; the first request is issued in the first cycle after release.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_CHK_EN defined, react to a redirect target with [1:0]!=0 by flushing as in REQ-026, setting o_insn_misalign=1 and halting requests until the next aligned redirect, which clears the flag.
REQ-032 SHALL, without FETCH_MISALIGN_CHK_EN, force target bits [1:0] to 0, omit the port o_insn_misalign and never halt.

Verification
REQ-033 SHALL cover reset release, memory always ready, 1-cycle response, i_instr_rdy=1 -> addresses 0,4,8,...; o_pc/o_instr match memory; one instruction per cycle after fill.
REQ-034 SHALL cover holding i_instr_rdy=0 for 5 cycles -> FIFO holds 2 entries, o_imem_req=0, no data lost; release -> pcs continue in sequence.
REQ-035 SHALL cover i_imem_ready=0 for 3 cycles -> o_imem_addr held constant; no fetch_pc advance.
REQ-036 SHALL cover a redirect to 32'h0000_0100 with 2 outstanding -> both stale responses dropped; next o_instr_vld has o_pc=0x100.
REQ-037 SHALL cover, with FETCH_MISALIGN_CHK_EN defined, a redirect to 32'h0000_0102 -> o_insn_misalign=1, o_imem_req=0; a later redirect to 0x200 -> flag clears and fetch resumes at 0x200.
REQ-038 SHALL cover i_rst asserted mid-stream with a pending response -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit handshake bundle: redirect, instruction-memory request/response and decode-side valid/ready.
// The misaligned-redirect flag exists only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_unit_if;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_instr_vld;
  logic        i_instr_rdy;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        o_insn_misalign;
`endif

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
    output o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld
`ifdef FETCH_MISALIGN_CHK_EN
    , output o_insn_misalign
`endif
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
    input  o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld
`ifdef FETCH_MISALIGN_CHK_EN
    , input o_insn_misalign
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, 2-entry {pc,instr} FIFO, redirect with stale-response drop.
// Latency: response -> o_instr_vld exactly 1 cycle. Backpressure: i_instr_rdy=0 fills the FIFO, which withholds credits.
// FETCH_MISALIGN_CHK_EN: flag and halt on misaligned redirect targets; otherwise targets are word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        i_clk,
  input logic        i_rst,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  outstanding_nxt;
  logic [2:0]  credits_used;
  logic [31:0] target;
  logic        halted;
  logic        hs;
  logic        push;
  logic        pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  logic target_bad;
  assign target     = bus.i_redirect_pc;
  assign target_bad = |bus.i_redirect_pc[1:0];
  assign halted     = misalign_q;
  assign bus.o_insn_misalign = misalign_q;
`else
  assign target = bus.i_redirect_pc & ~32'h0000_0003;
  assign halted = 1'b0;
`endif

  // Credits cover FIFO entries plus in-flight responses, so a push always has room.
  assign credits_used    = {1'b0, outstanding} + {1'b0, count};
  assign bus.o_imem_req  = !i_rst && (credits_used < 3'd2) && !halted;
  assign bus.o_imem_addr = fetch_pc;

  assign hs   = bus.o_imem_req && bus.i_imem_ready;
  assign push = bus.i_imem_rvalid && (drop == 2'd0) && !bus.i_redirect;
  assign pop  = bus.o_instr_vld && bus.i_instr_rdy && !bus.i_redirect;
  assign outstanding_nxt = outstanding + {1'b0, hs} - {1'b0, bus.i_imem_rvalid};

  assign bus.o_instr_vld = (count != 2'd0);
  assign bus.o_instr     = bus.o_instr_vld ? fifo_instr[rd_ptr] : NOP;
  assign bus.o_pc        = fifo_pc[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      fifo_pc[0]    <= RESET_PC;
      fifo_pc[1]    <= RESET_PC;
      fifo_instr[0] <= NOP;
      fifo_instr[1] <= NOP;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      outstanding   <= 2'd0;
      drop          <= 2'd0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.i_redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= outstanding_nxt;
        count    <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_q <= target_bad;
`endif
      end else begin
        if (hs) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (bus.i_imem_rvalid && (drop != 2'd0)) begin
          drop <= drop - 2'd1;
        end
        if (push) begin
          fifo_pc[wr_ptr]    <= resp_pc;
          fifo_instr[wr_ptr] <= bus.i_imem_rdata;
          wr_ptr             <= ~wr_ptr;
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem responder (1-cycle latency, holdable)
// and a running scoreboard on fetch addresses and delivered {pc,instr}.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_next_pc = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // One clock: sample handshakes/consumption before the edge, drive the memory response after it.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = bus.o_imem_req && bus.i_imem_ready;
    a  = bus.o_imem_addr;
    if (hs) begin
      chk("fetch_addr", a, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      pend_q.push_back(a);
    end
    if (bus.o_instr_vld && bus.i_instr_rdy && !bus.i_redirect) begin
      chk("seq_pc", bus.o_pc, exp_next_pc);
      chk("seq_instr", bus.o_instr, word(exp_next_pc));
      exp_next_pc = exp_next_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    if (!rst && !mem_hold && pend_q.size() > 0) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = word(pend_q.pop_front());
    end else begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = 32'h0;
    end
  endtask

  task automatic wait_vld(input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.o_instr_vld; i++) tick();
    chk("wait_vld", bus.o_instr_vld, 1'b1);
  endtask

  task automatic wait_rvalid(input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.i_imem_rvalid; i++) tick();
    chk("wait_rvalid", bus.i_imem_rvalid, 1'b1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = pc;
    tick();
    bus.i_redirect    = 1'b0;
  endtask

  initial begin
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_imem_ready  = 1'b1;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;
    bus.i_instr_rdy   = 1'b1;

    // Reset values, then first request right after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus.o_imem_req, 1'b0);
    chk("rst_vld", bus.o_instr_vld, 1'b0);
    chk("rst_instr", bus.o_instr, NOP);
    chk("rst_pc", bus.o_pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", bus.o_imem_req, 1'b1);
    chk("rel_addr", bus.o_imem_addr, 32'h0);
    tick();
    chk("c1_addr", bus.o_imem_addr, 32'h4);
    chk("c1_vld", bus.o_instr_vld, 1'b0);
    tick();
    chk("first_vld", bus.o_instr_vld, 1'b1);
    chk("first_pc", bus.o_pc, 32'h0);
    chk("first_instr", bus.o_instr, 32'hFFFF_FFFF);
    chk("credits_full_req", bus.o_imem_req, 1'b0);
    repeat (12) tick();

    // Downstream stall: FIFO fills to 2, requests stop, nothing lost
    bus.i_instr_rdy = 1'b0;
    repeat (5) tick();
    chk("stall_req", bus.o_imem_req, 1'b0);
    chk("stall_vld", bus.o_instr_vld, 1'b1);
    chk("stall_head", bus.o_pc, exp_next_pc);
    bus.i_instr_rdy = 1'b1;
    tick();
    chk("stall_2nd_vld", bus.o_instr_vld, 1'b1);
    repeat (6) tick();

    // Memory not ready: address held, no advance
    bus.i_imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_addr", bus.o_imem_addr, exp_fetch);
    end
    chk("hold_req", bus.o_imem_req, 1'b1);
    bus.i_imem_ready = 1'b1;
    repeat (6) tick();

    // Redirect to 0x100 with two responses outstanding
    mem_hold = 1'b1;
    repeat (6) tick();
    chk("two_out_req", bus.o_imem_req, 1'b0);
    chk("two_out_vld", bus.o_instr_vld, 1'b0);
    redirect(32'h0000_0100);
    exp_fetch   = 32'h0000_0100;
    exp_next_pc = 32'h0000_0100;
    mem_hold    = 1'b0;
    chk("redir_vld", bus.o_instr_vld, 1'b0);
    chk("redir_req", bus.o_imem_req, 1'b0);
    wait_vld(12);
    chk("redir_pc", bus.o_pc, 32'h0000_0100);
    chk("redir_instr", bus.o_instr, 32'hFFFF_FEFF);
    repeat (6) tick();

`ifdef FETCH_MISALIGN_CHK_EN
    redirect(32'h0000_0102);
    chk("mis_vld_next", bus.o_instr_vld, 1'b0);
    repeat (4) tick();
    chk("mis_flag", bus.o_insn_misalign, 1'b1);
    chk("mis_req", bus.o_imem_req, 1'b0);
    chk("mis_vld", bus.o_instr_vld, 1'b0);
    redirect(32'h0000_0200);
    exp_fetch   = 32'h0000_0200;
    exp_next_pc = 32'h0000_0200;
    chk("mis_clr", bus.o_insn_misalign, 1'b0);
    wait_vld(12);
    chk("resume_pc", bus.o_pc, 32'h0000_0200);
`else
    // Misaligned target is word-aligned; a response arriving in the redirect cycle is dropped
    wait_rvalid(10);
    redirect(32'h0000_0102);
    exp_fetch   = 32'h0000_0100;
    exp_next_pc = 32'h0000_0100;
    chk("align_vld_next", bus.o_instr_vld, 1'b0);
    wait_vld(12);
    chk("align_pc", bus.o_pc, 32'h0000_0100);
`endif
    repeat (6) tick();

    // Reset mid-stream with a response pending
    wait_rvalid(10);
    rst = 1'b1;
    bus.i_imem_rvalid = 1'b0;
    pend_q.delete();
    #1;
    chk("mid_rst_req", bus.o_imem_req, 1'b0);
    chk("mid_rst_vld", bus.o_instr_vld, 1'b0);
    chk("mid_rst_instr", bus.o_instr, NOP);
    chk("mid_rst_pc", bus.o_pc, 32'h0);
    repeat (2) tick();
    rst         = 1'b0;
    exp_fetch   = 32'h0;
    exp_next_pc = 32'h0;
    #1;
    chk("restart_addr", bus.o_imem_addr, 32'h0);
    chk("restart_req", bus.o_imem_req, 1'b1);
    wait_vld(12);
    chk("restart_pc", bus.o_pc, 32'h0);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
